// File: rtl/ff_bank.sv
// Multi-channel configurable storage bank: each channel behaves as a D, T, JK
// or single-clock latch-emulation register, with a registered change flag.
module ff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [2*CHANNELS-1:0]     mode_i,
  input  logic [CHANNELS-1:0]       gate_i,
  input  logic [CHANNELS*WIDTH-1:0] d_i,
  input  logic [CHANNELS*WIDTH-1:0] k_i,
  output logic [CHANNELS*WIDTH-1:0] q_o,
  output logic [CHANNELS*WIDTH-1:0] qn_o,
  output logic [CHANNELS-1:0]       chg_o
);

  localparam logic [1:0] MODE_D     = 2'b00;
  localparam logic [1:0] MODE_T     = 2'b01;
  localparam logic [1:0] MODE_JK    = 2'b10;
  localparam logic [1:0] MODE_LATCH = 2'b11;

  logic [CHANNELS*WIDTH-1:0] s_q, s_d;
  logic [CHANNELS-1:0]       chg_q, chg_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] s_cur;
    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] k_c;
    logic [WIDTH-1:0] s_nxt;
    logic [1:0]       mode_c;
    logic             transp;

    assign s_cur  = s_q[c*WIDTH +: WIDTH];
    assign d_c    = d_i[c*WIDTH +: WIDTH];
    assign k_c    = k_i[c*WIDTH +: WIDTH];
    assign mode_c = mode_i[2*c +: 2];

    always_comb begin
      s_nxt = s_cur;
      if (en_i[c]) begin
        case (mode_c)
          MODE_D:     s_nxt = d_c;
          MODE_T:     s_nxt = s_cur ^ d_c;
          MODE_JK:    s_nxt = (d_c & ~s_cur) | (~k_c & s_cur);
          MODE_LATCH: s_nxt = gate_i[c] ? d_c : s_cur;
          default:    s_nxt = s_cur;
        endcase
      end
    end

    assign s_d[c*WIDTH +: WIDTH] = s_nxt;
    assign chg_d[c]              = (s_nxt != s_cur);

    // Reset forces the stored view so q_o never shows d while rst_i is high.
    assign transp = (mode_c == MODE_LATCH) & en_i[c] & gate_i[c] & ~rst_i;
    assign q_o[c*WIDTH +: WIDTH] = transp ? d_c : s_cur;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q   <= {CHANNELS{RESET_VAL}};
      chg_q <= '0;
    end else begin
      s_q   <= s_d;
      chg_q <= chg_d;
    end
  end

  assign qn_o  = ~q_o;
  assign chg_o = chg_q;

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised multi-channel flip-flop bank that generalises the single-bit transparent D element into `CHANNELS` independent `WIDTH`-bit state registers. Each channel selects at run time between D, T, JK and latch-emulation (transparent) behaviour. Each channel also reports a registered change flag. It sits between control logic and datapath wherever the design needs configurable storage elements under one clock.

## Interface
- `WIDTH`, 8, bits per channel (>=1)
- `CHANNELS`, 4, number of independent channels (>=1)
- `RESET_VAL`, '0, WIDTH-bit value loaded into every channel on reset

- `clk_i`  in  1  single clock; all state updates on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `en_i`  in  CHANNELS  per-channel update enable
- `mode_i`  in  2*CHANNELS  per-channel mode, channel c at [2c+1:2c]: 00 D, 01 T, 10 JK, 11 LATCH
- `gate_i`  in  CHANNELS  per-channel transparency gate; used in LATCH mode only
- `d_i`  in  CHANNELS*WIDTH  per-channel data / toggle mask / J input, channel c at [c*WIDTH +: WIDTH]
- `k_i`  in  CHANNELS*WIDTH  per-channel K input; used in JK mode only
- `q_o`  out  CHANNELS*WIDTH  per-channel output
- `qn_o`  out  CHANNELS*WIDTH  bitwise inverse of `q_o`, always
- `chg_o`  out  CHANNELS  registered flag: channel state changed at the previous edge

## Operation
Each channel c holds a state register s[c] (WIDTH bits) and a flag register chg[c].

Rising edge, in priority order:
- `rst_i`=1: s[c] <= RESET_VAL and chg[c] <= 0 for all c. Reset overrides `en_i`, mode and gate.
- `en_i[c]`=0: s[c] holds.
- `en_i[c]`=1, mode 00 (D): s <= d.
- `en_i[c]`=1, mode 01 (T): s <= s ^ d. The d input is a bitwise toggle mask.
- `en_i[c]`=1, mode 10 (JK): per bit, s <= (j & ~s) | (~k & s), with j=d.
  - j=0, k=0: hold
  - j=1, k=0: set
  - j=0, k=1: clear
  - j=1, k=1: toggle
- `en_i[c]`=1, mode 11 (LATCH): s <= d if `gate_i[c]`=1, else hold.
- chg[c] <= (next s[c] != s[c]) when not in reset. A hold or a reload of an identical value gives 0.

Outputs:
- Channel c is transparent when all of the following hold: mode 11, `en_i[c]`=1, `gate_i[c]`=1, `rst_i`=0.
  - Transparent: `q_o[c]` = d[c], combinational.
  - Otherwise: `q_o[c]` = s[c].
- `chg_o[c]` = chg[c].
- `qn_o` = ~`q_o`, including during transparency.
- Channels are fully independent. No cross-channel interaction.

Mode changes:
- A new `mode_i` value takes effect at the same edge it is sampled.
- s is never cleared by a mode change.
- Leaving LATCH while transparent: `q_o` immediately shows s, i.e. the value captured at the last edge.

## Timing
- Reset values: every `q_o` channel = RESET_VAL, `qn_o` = ~RESET_VAL, `chg_o` = 0. Valid from the first edge with `rst_i`=1; `q_o` stays at s during reset because reset forces non-transparency.
- Modes D, T, JK: `q_o` latency is 1 cycle from input sample to output.
- LATCH mode:
  - d to `q_o` latency is 0 cycles (combinational) while transparent.
  - When the gate falls, `q_o` shows d as sampled at the last rising edge with the gate high.
  - d changes between that edge and gate fall are not retained. This is intended single-clock latch emulation.
- `chg_o` is asserted for exactly the cycle after the edge that changed s. Consecutive changing edges keep it high continuously.
- Reset asserted mid-operation: the next edge forces RESET_VAL and chg=0. The step from a non-reset value to RESET_VAL does not raise `chg_o`.
- The first edge after `rst_i` deasserts behaves as a normal update.
- No combinational path from `d_i`/`gate_i`/`en_i` to `chg_o`.

## Test plan
- Reset: WIDTH=8, CHANNELS=4, RESET_VAL=8'hA5, `rst_i`=1 for 2 cycles with random inputs -> all `q_o`=8'hA5, `qn_o`=8'h5A, `chg_o`=0. Release with `en_i`=0 -> values held, `chg_o`=0.
- D mode, channel 0:
  - d=8'h3C, en=1 -> `q_o` ch0 = 8'h3C one cycle later, `chg_o[0]`=1 for one cycle.
  - Same d reapplied -> `chg_o[0]`=0.
  - Channels 1-3 (en=0) unchanged.
- T mode: s=8'h0F, d=8'hFF for 2 edges -> 8'hF0 then 8'h0F. d=8'h00 -> hold, `chg_o`=0.
- JK mode: s=8'b1100_1100, j=8'b1010_1010, k=8'b0110_0110 -> s=8'b1010_1010, exercising hold/set/clear/toggle per bit pair.
- LATCH mode, channel 2:
  - gate=1, d walks 8'h11 -> 8'h22 mid-cycle -> `q_o` follows in the same cycle.
  - Edge with d=8'h22, then d=8'h33 and gate falls before the next edge -> `q_o`=8'h22.
  - gate=0 and d changes -> `q_o` stays 8'h22.
- Reset mid-LATCH transparency: `rst_i`=1 while gate=1, d=8'h77 -> `q_o` = s immediately (non-transparent), RESET_VAL after the edge, `chg_o`=0. Simultaneously switch ch3 from JK to D -> ch3 also at RESET_VAL.
